// File: rtl/fp32_pkg.sv
// Shared definitions for the binary32 multiplier: field widths, exponent
// constants, the canonical quiet NaN, the sequencing FSM states and a
// struct view of a binary32 word for field extraction.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 1;  // frac with hidden leading one
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    MUL,
    DONE
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp32_mul_core.sv
// Combinational binary32 multiply: special-case decode, 24x24 significand
// product, single-step normalization and round-to-nearest-even.
// Denormal inputs are treated as zero and underflow flushes to signed zero.
//
// Ports:
//   op_a, op_b : binary32 operands
//   result     : binary32 product
module fp32_mul_core
  import fp32_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result
);

  fp32_t a_f;
  fp32_t b_f;
  assign a_f = op_a;
  assign b_f = op_b;

  logic sign;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign   = a_f.sign ^ b_f.sign;
  // Exponent field 0 covers both true zero and denormals.
  assign a_zero = (a_f.exp == '0);
  assign b_zero = (b_f.exp == '0);
  assign a_inf  = (a_f.exp == EXP_W'(EXP_MAX)) && (a_f.frac == '0);
  assign b_inf  = (b_f.exp == EXP_W'(EXP_MAX)) && (b_f.frac == '0);
  assign a_nan  = (a_f.exp == EXP_W'(EXP_MAX)) && (a_f.frac != '0);
  assign b_nan  = (b_f.exp == EXP_W'(EXP_MAX)) && (b_f.frac != '0);

  logic [2*MANT_W-1:0] prod;
  assign prod = {1'b1, a_f.frac} * {1'b1, b_f.frac};

  logic               [FRAC_W-1:0] mant;
  logic                            guard;
  logic                            sticky;
  logic                            round_up;
  logic               [MANT_W-1:0] mant_rnd;
  logic signed        [9:0]        exp_norm;
  logic signed        [9:0]        exp_rnd;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    mant     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    round_up = 1'b0;
    mant_rnd = '0;
    exp_norm = '0;
    exp_rnd  = '0;
    result   = '0;

    // Product lies in [1,4); bit 47 set means shift right by one.
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    // 10-bit signed so both overflow past 255 and underflow below 1 are visible.
    exp_norm = 10'(a_f.exp) + 10'(b_f.exp) + 10'(prod[47]) - 10'(BIAS);

    // Ties go to even: round up on guard unless exactly halfway with even lsb.
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + MANT_W'(round_up);
    // A carry-out leaves the fraction all-zero, so only the exponent moves.
    exp_rnd  = exp_norm + 10'(mant_rnd[FRAC_W]);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result = QNAN;
    end else if (a_inf || b_inf) begin
      result = {sign, EXP_W'(EXP_MAX), {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      result = {sign, 31'd0};
    end else if (exp_rnd >= 10'sd255) begin
      result = {sign, EXP_W'(EXP_MAX), {FRAC_W{1'b0}}};
    end else if (exp_rnd <= 10'sd0) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, exp_rnd[7:0], mant_rnd[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// Sequential binary32 multiplier sharing one 32-bit operand bus. A free-
// running FSM captures operand A, then operand B on the next cycle, registers
// the product on the third edge and pulses ready for one cycle afterwards.
//
// Ports:
//   clock   : rising-edge clock
//   nreset  : asynchronous active-low reset
//   a       : operand bus (A then B on consecutive cycles)
//   product : registered binary32 product, held until the next result
//   ready   : one-cycle pulse while a new product is presented
module fp_multiplier
  import fp32_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic [31:0] a,
  output logic [31:0] product,
  output logic        ready
);

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] product_q, product_d;
  logic        ready_q, ready_d;
  logic [31:0] mul_result;

  fp32_mul_core u_core (
    .op_a   (op_a_q),
    .op_b   (op_b_q),
    .result (mul_result)
  );

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= LOAD_A;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic: the sequence free-runs with no handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = MUL;
      MUL:     state_d = DONE;
      DONE:    state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Output/datapath logic: decides what each register loads this cycle.
  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    product_d = product_q;
    ready_d   = 1'b0;
    case (state_q)
      LOAD_A: op_a_d = a;
      LOAD_B: op_b_d = a;
      MUL: begin
        product_d = mul_result;
        // Registered so ready rises with product and lasts through DONE.
        ready_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  assign product = product_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed bench for fp_multiplier: hand-computed binary32 products, ready
// timing, product hold behaviour and a reset during operand B.
module tb_fp_multiplier;

  logic        clock;
  logic        nreset;
  logic [31:0] a;
  logic [31:0] product;
  logic        ready;

  int n_checks = 0;
  int n_errors = 0;

  fp_multiplier dut (
    .clock   (clock),
    .nreset  (nreset),
    .a       (a),
    .product (product),
    .ready   (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Entered at a falling edge with the DUT in LOAD_A; returns at the falling
  // edge after DONE, again in LOAD_A. prev is the product expected to be held
  // until the MUL edge.
  task automatic run_op(input string name, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] prev,
                        input logic [31:0] expected);
    a = op_a;
    @(posedge clock);
    @(negedge clock);
    check({name, " ready LOAD_B"}, 32'(ready), 32'd0);
    check({name, " hold LOAD_B"}, product, prev);
    a = op_b;
    @(posedge clock);
    @(negedge clock);
    check({name, " ready MUL"}, 32'(ready), 32'd0);
    check({name, " hold MUL"}, product, prev);
    a = 32'hDEAD_BEEF;  // bus noise must not reach the result
    @(posedge clock);
    @(negedge clock);
    check({name, " product"}, product, expected);
    check({name, " ready pulse"}, 32'(ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check({name, " ready low"}, 32'(ready), 32'd0);
    check({name, " hold LOAD_A"}, product, expected);
  endtask

  initial begin
    nreset = 1'b0;
    a      = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset product", product, 32'h0);
    check("reset ready", 32'(ready), 32'd0);
    nreset = 1'b1;

    run_op("neg_mul",   32'hC480_0000, 32'h3D40_0000, 32'h0,          32'hC240_0000);
    run_op("one5x2",    32'h3FC0_0000, 32'h4000_0000, 32'hC240_0000,  32'h4040_0000);
    run_op("zero",      32'h0000_0000, 32'hC480_0000, 32'h4040_0000,  32'h8000_0000);
    run_op("inf_x0",    32'h7F80_0000, 32'h0000_0000, 32'h8000_0000,  32'h7FC0_0000);
    run_op("overflow",  32'h7F00_0000, 32'h7F00_0000, 32'h7FC0_0000,  32'h7F80_0000);
    run_op("underflow", 32'h0080_0000, 32'h0080_0000, 32'h7F80_0000,  32'h0000_0000);
    run_op("rnd_lsb",   32'h3F80_0001, 32'h3F80_0001, 32'h0000_0000,  32'h3F80_0002);
    run_op("rnd_max",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3F80_0002,  32'h407F_FFFE);
    run_op("inf_neg",   32'h7F80_0000, 32'hC000_0000, 32'h407F_FFFE,  32'hFF80_0000);
    run_op("nan",       32'h7FA0_0000, 32'h3F80_0000, 32'hFF80_0000,  32'h7FC0_0000);

    // Reset while in LOAD_B: outputs clear immediately, operands discarded.
    a = 32'h4000_0000;
    @(posedge clock);
    @(negedge clock);
    nreset = 1'b0;
    #1;
    check("midrst product", product, 32'h0);
    check("midrst ready", 32'(ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    run_op("post_rst",  32'h4040_0000, 32'h4080_0000, 32'h0,          32'h4140_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fp_multiplier.md
# fp_multiplier

Sequential IEEE-754 single-precision multiplier with a single 32-bit operand port. The two operands arrive serially on consecutive clock cycles, and the block returns the registered product with a one-cycle `ready` pulse. It is a leaf arithmetic block for datapaths that stream operands over a shared bus and need a 32-bit float multiply.

## Interface
- No parameters; widths fixed at 32-bit IEEE-754 binary32.
- `clock  input  1`  single clock, rising-edge.
- `nreset  input  1`  asynchronous, active-low reset.
- `a  input  32`  operand bus; first operand on one cycle, second on the next.
- `product  output  32`  registered binary32 product; holds until next result.
- `ready  output  1`  high for exactly one cycle when `product` is updated.

## Operation
- FSM states: LOAD_A, LOAD_B, MUL, DONE. Reset state LOAD_A.
  - LOAD_A: capture `a` into opA; go to LOAD_B.
  - LOAD_B: capture `a` into opB; go to MUL.
  - MUL: compute opA×opB; register into `product`; go to DONE.
  - DONE: `ready`=1; go to LOAD_A.
- The FSM cycles continuously; there is no start/valid input. The bench must present operand A on the first edge after reset release, or immediately after a DONE cycle.
- Sign: signA XOR signB, applied in all cases, including zero and infinity.
- Normal path:
  - 24×24 multiply of {1,mantissa}, giving a 48-bit product.
  - Exponent = expA + expB − 127, with +1 if product bit 47 is set (normalize right by one).
  - Compute the exponent in 10-bit signed arithmetic.
- Rounding: round-to-nearest-even using guard bit and sticky OR of the remaining bits. A mantissa carry-out increments the exponent.
- Special cases:
  - Denormal inputs are treated as zero.
  - Either operand zero (and the other finite) → signed zero.
  - Either operand NaN, or Inf×0 → quiet NaN 0x7FC00000.
  - Inf × finite nonzero → signed infinity.
  - Exponent ≥255 after rounding → signed infinity.
  - Exponent ≤0 → signed zero (flush, no denormal output).
- The `product` register holds its value through LOAD_A, LOAD_B and DONE of the next operation; it changes only at the MUL→DONE edge.

## Timing
- Reset (async assert, any time): `product`=0, `ready`=0, opA=opB=0, state=LOAD_A. A reset mid-operation discards captured operands.
- Reset release is effectively synchronous to the next rising edge; that edge is the LOAD_A capture.
- With A sampled at edge k:
  - B is sampled at edge k+1.
  - `product` is updated at edge k+2.
  - `ready` is high from edge k+2 to edge k+3.
  - The next A is sampled at edge k+3.
- Throughput: one result per 4 cycles. Latency from A capture to result: 2 edges.
- `ready` is a registered output, with no combinational path from `a`.

## Structure
- Shared package `fp32_pkg`:
  - field widths, BIAS=127, EXP_MAX=255
  - QNAN=32'h7FC00000
  - state enum {LOAD_A, LOAD_B, MUL, DONE}
  - field-extract helper typedef (sign/exp/frac struct).
- One sub-module, `fp32_mul_core`: purely combinational opA,opB → result, covering specials, multiply, normalize and round.
- The top level holds the FSM, operand registers and output registers.

## Test plan
- Reset low 2 cycles, then drive 0xC4800000 (−1024.0) for A and 0x3D400000 (0.046875) for B → `product`=0xC2400000 (−48.0), `ready` pulse exactly one cycle at edge k+2.
- A=0x3FC00000 (1.5), B=0x40000000 (2.0) → 0x40400000 (3.0). Hold `product` for the following 3 cycles.
- A=0x00000000, B=0xC4800000 → 0x80000000. A=0x7F800000, B=0x00000000 → 0x7FC00000.
- A=0x7F000000, B=0x7F000000 → 0x7F800000 (overflow). A=0x00800000, B=0x00800000 → 0x00000000 (underflow flush).
- Rounding: A=B=0x3F800001 → 0x3F800002. A=B=0x3FFFFFFF → 0x407FFFFE.
- Assert `nreset` during LOAD_B → `product`=0 and `ready`=0 immediately. After release, the next two inputs are treated as fresh A and B.
